// File: rtl/spi_pkg.sv
// Shared definitions for the SPI stream bridge: register map offsets,
// CTRL/STATUS bit positions and the transfer sequencer state encoding.
package spi_pkg;

    // Register word offsets on the peripheral bus
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

    // CTRL bit positions
    localparam int CTRL_POL      = 0;
    localparam int CTRL_PHA      = 1;
    localparam int CTRL_CS_AUTO  = 2;
    localparam int CTRL_CS_FORCE = 3;

    // STATUS bit positions
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_ACTIVE   = 4;
    localparam int STAT_TX_OVF   = 5;

    // IRQ_EN bit positions
    localparam int IRQ_RX_NOT_EMPTY  = 0;
    localparam int IRQ_TX_EMPTY_IDLE = 1;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_RISE = 2'd2,
        WAIT_FALL = 2'd3
    } spi_state_e;

    // Assemble the STATUS readback word from its individual flags
    function automatic logic [31:0] status_word(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_full,
        input logic rx_empty,
        input logic active,
        input logic tx_ovf
    );
        logic [31:0] w;
        w                = '0;
        w[STAT_TX_FULL]  = tx_full;
        w[STAT_TX_EMPTY] = tx_empty;
        w[STAT_RX_FULL]  = rx_full;
        w[STAT_RX_EMPTY] = rx_empty;
        w[STAT_ACTIVE]   = active;
        w[STAT_TX_OVF]   = tx_ovf;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// A push and a pop in the same cycle leave the count unchanged, including
// when the FIFO is full (the pop frees the slot the push fills).
// Pointers are log2(DEPTH) bits and wrap naturally; count carries one extra bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_stream_bridge.sv
// Memory-mapped front end for the byte-level SPI controller.
// CPU writes queue bytes in a TX FIFO; a small sequencer hands them one at a
// time to the controller and captures each received byte into an RX FIFO.
// Optional feature macro: SPI_BRIDGE_IRQ_EN enables the IRQ_EN register and
// the level interrupt; without it IRQ_EN reads 0 and irq is tied low.
//
// Controller handshake: the sequencer pulses ctl_trigger for one cycle with
// ctl_tx_data already stable, waits for ctl_busy to rise, then for it to fall;
// ctl_rx_data is taken on the cycle ctl_busy is seen low again. ctl_tx_data
// holds until the next transfer is loaded.
module spi_stream_bridge
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        ctl_trigger,
    output logic [7:0]  ctl_tx_data,
    input  logic [7:0]  ctl_rx_data,
    input  logic        ctl_busy,
    output logic        ctl_pol,
    output logic        ctl_pha,
    output logic        cs_n,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    spi_state_e  state;
    logic [3:0]  ctrl;
    logic        tx_ovf;
    logic [1:0]  irq_en;

    logic        tx_full;
    logic        tx_empty;
    logic [7:0]  tx_head;
    logic        tx_push;
    logic        tx_pop;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        rx_push;
    logic        rx_pop;

    logic        wr_data;
    logic        wr_status;
    logic        wr_ctrl;
    logic        wr_irq_en;
    logic        rd_data;
    logic        active;
    logic        unused_wdata;

    // Bus decode
    assign wr_data   = bus_sel & bus_we & (bus_addr == ADDR_DATA);
    assign wr_status = bus_sel & bus_we & (bus_addr == ADDR_STATUS);
    assign wr_ctrl   = bus_sel & bus_we & (bus_addr == ADDR_CTRL);
    assign wr_irq_en = bus_sel & bus_we & (bus_addr == ADDR_IRQ_EN);
    assign rd_data   = bus_sel & ~bus_we & (bus_addr == ADDR_DATA);

    assign unused_wdata = ^bus_wdata[31:8];

    assign active    = (state != IDLE);
    assign dbg_state = state;

    // A transfer starts only when there is a byte to send, room for the reply
    // and the controller is not still finishing a previous shift.
    assign tx_pop  = (state == IDLE) & ~tx_empty & ~rx_full & ~ctl_busy;
    // A write to a full TX FIFO still lands if the sequencer pops that cycle.
    assign tx_push = wr_data & (~tx_full | tx_pop);
    assign rx_push = (state == WAIT_FALL) & ~ctl_busy;
    assign rx_pop  = rd_data & ~rx_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (bus_wdata[7:0]),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (ctl_rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Transfer sequencer with registered trigger and transmit byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ctl_trigger <= 1'b0;
            ctl_tx_data <= 8'h00;
        end else begin
            ctl_trigger <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_pop) begin
                        ctl_tx_data <= tx_head;
                        ctl_trigger <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (ctl_busy) begin
                        state <= WAIT_FALL;
                    end
                end
                WAIT_FALL: begin
                    if (!ctl_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // CTRL register and sticky TX overflow flag (cleared by writing 1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl   <= 4'h0;
            tx_ovf <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= bus_wdata[3:0];
            end
            if (wr_data && tx_full && !tx_pop) begin
                tx_ovf <= 1'b1;
            end else if (wr_status && bus_wdata[STAT_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end
        end
    end

    // Mode outputs only move while idle so a shift never sees its mode change;
    // a CTRL write in the same idle cycle is picked up directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_pol <= 1'b0;
            ctl_pha <= 1'b0;
        end else if (state == IDLE) begin
            ctl_pol <= wr_ctrl ? bus_wdata[CTRL_POL] : ctrl[CTRL_POL];
            ctl_pha <= wr_ctrl ? bus_wdata[CTRL_PHA] : ctrl[CTRL_PHA];
        end
    end

    // Chip select: forced, or automatic while work is pending or in flight
    assign cs_n = ~(ctrl[CTRL_CS_FORCE] |
                    (ctrl[CTRL_CS_AUTO] & (active | ~tx_empty)));

`ifdef SPI_BRIDGE_IRQ_EN
    // Interrupt enable register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 2'b00;
        end else if (wr_irq_en) begin
            irq_en <= bus_wdata[1:0];
        end
    end

    assign irq = (irq_en[IRQ_RX_NOT_EMPTY] & ~rx_empty) |
                 (irq_en[IRQ_TX_EMPTY_IDLE] & tx_empty & ~active);
`else
    logic unused_irq_wr;
    assign unused_irq_wr = wr_irq_en;
    assign irq_en        = 2'b00;
    assign irq           = 1'b0;
`endif

    // Read mux, combinational from current state
    always_comb begin
        bus_rdata = 32'h0;
        case (bus_addr)
            ADDR_DATA:   bus_rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
            ADDR_STATUS: bus_rdata = status_word(tx_full, tx_empty, rx_full,
                                                 rx_empty, active, tx_ovf);
            ADDR_CTRL:   bus_rdata = {28'h0, ctrl};
            ADDR_IRQ_EN: bus_rdata = {30'h0, irq_en};
            default:     bus_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_spi_stream_bridge.sv
// Testbench for spi_stream_bridge with a loopback controller model
// (received byte = transmitted byte) and a trigger scoreboard.
module tb_spi_stream_bridge;

    logic        clk;
    logic        rst_n;
    logic        bus_sel;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        ctl_trigger;
    logic [7:0]  ctl_tx_data;
    logic [7:0]  ctl_rx_data;
    logic        ctl_busy;
    logic        ctl_pol;
    logic        ctl_pha;
    logic        cs_n;
    logic        irq;
    logic [1:0]  dbg_state;

    logic [7:0]  exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          trig_cnt = 0;
    int          busy_len = 4;

    spi_stream_bridge #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_sel     (bus_sel),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .ctl_trigger (ctl_trigger),
        .ctl_tx_data (ctl_tx_data),
        .ctl_rx_data (ctl_rx_data),
        .ctl_busy    (ctl_busy),
        .ctl_pol     (ctl_pol),
        .ctl_pha     (ctl_pha),
        .cs_n        (cs_n),
        .irq         (irq),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(posedge clk); #1;
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        d = bus_rdata;
        @(posedge clk); #1;
        bus_sel = 1'b0;
        check(name, d, exp);
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(2'd0, {24'h0, b});
    endtask

    task automatic wait_trig(input int n);
        int budget = 500;
        while (trig_cnt < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("wait_trig_reached", (trig_cnt >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_state(input logic [1:0] s);
        int budget = 500;
        @(negedge clk);
        while (!(dbg_state == s && (s != 2'd0 || !ctl_busy)) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("wait_state_reached", {30'h0, dbg_state}, {30'h0, s});
    endtask

    // loopback controller model
    initial begin
        logic [7:0] b;
        int n;
        ctl_busy    = 1'b0;
        ctl_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && ctl_trigger) begin
                b = ctl_tx_data;
                n = busy_len;
                @(posedge clk); #1;
                ctl_busy = 1'b1;
                repeat (n) @(posedge clk);
                #1;
                ctl_busy    = 1'b0;
                ctl_rx_data = b;
            end
        end
    end

    // scoreboard monitor: every trigger must carry the next expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ctl_trigger) begin
                trig_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL trigger_unexpected actual=0x%0h expected=none", ctl_tx_data);
                end else begin
                    check("trigger_tx_data", {24'h0, ctl_tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // directed stimulus
    initial begin
        int base;
        rst_n = 1'b0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_cs_n", {31'h0, cs_n}, 1);
        check("rst_trigger", {31'h0, ctl_trigger}, 0);
        check("rst_tx_data", {24'h0, ctl_tx_data}, 0);
        check("rst_irq", {31'h0, irq}, 0);
        check("rst_state", {30'h0, dbg_state}, 0);
        check_read("rst_status", 2'd1, 32'h0A);
        check_read("rst_ctrl", 2'd2, 32'h0);

        // 1: single byte with automatic chip select
        bus_write(2'd2, 32'h4);
        @(negedge clk);
        check("t1_cs_n_idle", {31'h0, cs_n}, 1);
        push_byte(8'hA5);
        @(negedge clk);
        check("t1_cs_n_low", {31'h0, cs_n}, 0);
        check("t1_no_early_trigger", {31'h0, ctl_trigger}, 0);
        wait_trig(1);
        wait_state(2'd0);
        check_read("t1_status_rx", 2'd1, 32'h02);
        check("t1_cs_n_done", {31'h0, cs_n}, 1);
        check_read("t1_data", 2'd0, 32'hA5);
        check_read("t1_status_after", 2'd1, 32'h0A);
        check_read("t1_data_empty", 2'd0, 32'h0);

        // 2: overflow on the fifth queued byte, W1C, ordered drain
        busy_len = 30;
        base = trig_cnt;
        push_byte(8'h10);
        wait_trig(base + 1);
        for (int i = 1; i <= 4; i++) push_byte(8'h10 + i[7:0]);
        bus_write(2'd0, 32'h15);
        check_read("t2_status_ovf", 2'd1, 32'h39);
        bus_write(2'd1, 32'h20);
        check_read("t2_status_w1c", 2'd1, 32'h19);
        busy_len = 4;
        wait_trig(base + 4);
        wait_state(2'd0);
        check_read("t2_data0", 2'd0, 32'h10);
        wait_trig(base + 5);
        wait_state(2'd0);
        for (int i = 1; i <= 4; i++) check_read("t2_data", 2'd0, 32'h10 + i);

        // 3: RX full stalls the fifth transfer until a read
        base = trig_cnt;
        for (int i = 1; i <= 6; i++) push_byte(8'h20 + i[7:0]);
        wait_trig(base + 4);
        wait_state(2'd0);
        repeat (20) @(negedge clk);
        check("t3_stalled_count", trig_cnt - base, 4);
        check("t3_stalled_idle", {30'h0, dbg_state}, 0);
        check_read("t3_status_full", 2'd1, 32'h04);
        check_read("t3_data1", 2'd0, 32'h21);
        wait_trig(base + 5);
        wait_state(2'd0);
        check_read("t3_data2", 2'd0, 32'h22);
        wait_trig(base + 6);
        wait_state(2'd0);
        for (int i = 3; i <= 6; i++) check_read("t3_data", 2'd0, 32'h20 + i);

        // 4: pol write mid-transfer applies only at the next idle
        busy_len = 20;
        base = trig_cnt;
        push_byte(8'h5A);
        wait_trig(base + 1);
        bus_write(2'd2, 32'h5);
        @(negedge clk);
        check("t4_pol_held", {31'h0, ctl_pol}, 0);
        check_read("t4_ctrl_reg", 2'd2, 32'h5);
        push_byte(8'h6B);
        check("t4_pol_held2", {31'h0, ctl_pol}, 0);
        wait_trig(base + 2);
        check("t4_pol_applied", {31'h0, ctl_pol}, 1);
        check("t4_pha", {31'h0, ctl_pha}, 0);
        wait_state(2'd0);
        check_read("t4_data0", 2'd0, 32'h5A);
        check_read("t4_data1", 2'd0, 32'h6B);
        bus_write(2'd2, 32'h4);

        // 5: reset in WAIT_FALL clears everything at once
        base = trig_cnt;
        push_byte(8'h77);
        wait_trig(base + 1);
        wait_state(2'd3);
        bus_write(2'd0, 32'h88);
        @(negedge clk);
        exp_q.delete();
        bus_addr = 2'd1;
        rst_n = 1'b0;
        #1;
        check("t5_cs_n", {31'h0, cs_n}, 1);
        check("t5_trigger", {31'h0, ctl_trigger}, 0);
        check("t5_state", {30'h0, dbg_state}, 0);
        check("t5_status", bus_rdata, 32'h0A);
        check("t5_tx_data", {24'h0, ctl_tx_data}, 0);
        repeat (25) @(posedge clk);
        #1 rst_n = 1'b1;
        check_read("t5_status_after", 2'd1, 32'h0A);
        check_read("t5_ctrl_after", 2'd2, 32'h0);

        // 6: interrupt
        busy_len = 4;
`ifdef SPI_BRIDGE_IRQ_EN
        bus_write(2'd3, 32'h1);
        check_read("t6_irq_en", 2'd3, 32'h1);
        check("t6_irq_quiet", {31'h0, irq}, 0);
        base = trig_cnt;
        push_byte(8'h3C);
        wait_trig(base + 1);
        wait_state(2'd3);
        check("t6_irq_before_push", {31'h0, irq}, 0);
        wait_state(2'd0);
        check("t6_irq_rise", {31'h0, irq}, 1);
        check_read("t6_data", 2'd0, 32'h3C);
        @(negedge clk);
        check("t6_irq_fall", {31'h0, irq}, 0);
        bus_write(2'd3, 32'h2);
        @(negedge clk);
        check("t6_irq_tx_idle", {31'h0, irq}, 1);
        bus_write(2'd3, 32'h0);
`else
        bus_write(2'd3, 32'h3);
        check_read("t6_irq_en_zero", 2'd3, 32'h0);
        check("t6_irq_tied", {31'h0, irq}, 0);
`endif

        repeat (5) @(negedge clk);
        check("final_exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
